move_avg_stream: RTL
====================

Name: move_avg_stream

Overview:
Parametrised streaming moving-average filter for the mixer's 24-bit audio path. It supports a power-of-two window length and several time-interleaved channels, each with its own history and running sum. It uses a proper valid/ready handshake with backpressure and has an N-sample delay bypass mode. It sits between the audio source and the mixer sink, replacing the fixed 7-tap, stall-free filter.

Parameters:
DATA_W, 24, sample width in bits (signed two's complement)
LOG2_TAPS, 3, window length N = 2**LOG2_TAPS (legal range 1..6)
CHANNELS, 2, number of interleaved channels (legal range 1..8)
CH_W, derived = max(1, $clog2(CHANNELS)), channel index width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset
in_data  in  DATA_W  signed input sample
in_channel  in  CH_W  channel index of in_data
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
switch  in  1  1 = average, 0 = bypass (delay)
out_data  out  DATA_W  signed result
out_channel  out  CH_W  channel index of out_data
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result

Behaviour:
- Reset: reset is synchronous and active-high on clock clk.
  - Outputs during reset: out_data=0, out_channel=0, out_valid=0, in_ready=0.
  - All per-channel write pointers and running sums are cleared to 0.
  - FSM goes to CLEAR.
- FSM state CLEAR:
  - Walks history RAM addresses 0..N*CHANNELS-1, writing 0 to one address per cycle.
  - in_ready=0 throughout.
  - Goes to RUN after the last write, so in_ready rises exactly N*CHANNELS cycles after reset deasserts.
- FSM state RUN: in_ready = !out_valid | out_ready (one-deep output register, no combinational in_valid->in_ready path).
- Reset asserted in any state aborts the current activity, clears state as above and restarts CLEAR. Any in-flight output is discarded.
- Accept: in_valid & in_ready.
  - Let c = in_channel and x_old = hist[c][ptr[c]].
  - Update: sum[c] <= sum[c] + in_data - x_old; hist[c][ptr[c]] <= in_data; ptr[c] <= ptr[c]+1 (wraps N-1 -> 0).
- Sum arithmetic: sum width DATA_W+LOG2_TAPS, signed. It never overflows because it holds exactly N samples.
- Result, registered one cycle after accept (latency 1):
  - switch=1: out_data = (sum_new >>> LOG2_TAPS), truncated to DATA_W (floor division by N).
  - switch=0: out_data = x_old, i.e. a pure delay of N samples on that channel.
  - out_channel = c.
- Warm-up: history is zero after CLEAR. The first N-1 averages of a channel therefore include zeros, and the first N bypass outputs are 0.
- switch is sampled on the accept cycle. sum and history update in both modes, so toggling switch never glitches or needs re-warm-up.
- Out-of-range channel: in_channel >= CHANNELS is accepted (consumed) but changes no state and produces no output.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_channel hold stable and no new sample is accepted.
- Simultaneous events: an output transfer and a new accept in the same cycle load the next result with no bubble. Sustained throughput is 1 sample/cycle.
- No accept and no pending output: out_valid=0 and out_data=0.

Optional Feature:
MOVE_AVG_ROUND_EN
- Defined: in average mode, out_data = (sum_new + 2**(LOG2_TAPS-1)) >>> LOG2_TAPS (round half up). The add is done at DATA_W+LOG2_TAPS+1 bits. Bypass mode is unaffected.
- Undefined: floor division as above; no rounding adder is built.

Test Plan (LOG2_TAPS=3, CHANNELS=2 unless noted):
1. Release reset with in_valid=1 -> in_ready=0 for exactly 16 cycles, then 1. No output during CLEAR.
2. switch=1, ch0, eight samples of 800 with out_ready=1 -> out_data 100,200,...,800, each 1 cycle after accept, out_channel=0.
3. switch=1, ch0, eight samples of -4 -> first output -1 without MOVE_AVG_ROUND_EN, 0 with it. Eighth output is -4 in both builds.
4. Alternate ch0=+8 and ch1=-8 every cycle -> outputs 1,-1,2,-2,...,8,-8, with channels never mixing.
5. Hold out_ready=0 for 3 cycles with an output pending -> out_data/out_channel stable, in_ready=0, no sample lost or duplicated. Then release: back-to-back flow resumes with no bubble.
6. switch=0, ch0 samples 1..10 -> eight outputs of 0, then 1,2. Assert reset after sample 5, then feed 9 -> after CLEAR, the first bypass output is 0 and the first average is 1.

Source files
------------

// File: rtl/move_avg_stream.sv
// Streaming per-channel moving-average filter with N-sample delay bypass and valid/ready flow control.
// Optional build macro MOVE_AVG_ROUND_EN selects round-half-up averaging instead of floor.
module move_avg_stream #(
    parameter int DATA_W    = 24,
    parameter int LOG2_TAPS = 3,
    parameter int CHANNELS  = 2,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_channel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              switch,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_channel,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int TAPS   = 2 ** LOG2_TAPS;
    localparam int SUM_W  = DATA_W + LOG2_TAPS;
    localparam int ADDR_W = CH_W + LOG2_TAPS;
    localparam int DEPTH  = TAPS * CHANNELS;

    localparam logic [CH_W:0]     CH_NUM    = (CH_W + 1)'(CHANNELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        clr_addr_q;
    logic [LOG2_TAPS-1:0]     ptr_q [CHANNELS];
    logic signed [SUM_W-1:0]  sum_q [CHANNELS];
    logic [DATA_W-1:0]        hist_q [DEPTH];
    logic [DATA_W-1:0]        out_data_q;
    logic [CH_W-1:0]          out_channel_q;
    logic                     out_valid_q;

    logic                     ch_ok;
    logic                     accept;
    logic                     hit;
    logic [CH_W-1:0]          ch_idx;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        x_old;
    logic signed [SUM_W-1:0]  sum_new;
    logic [DATA_W-1:0]        avg;
    logic [DATA_W-1:0]        result_d;
`ifdef MOVE_AVG_ROUND_EN
    logic signed [SUM_W:0]    sum_rnd;
    logic signed [SUM_W:0]    sum_shr;
`else
    logic signed [SUM_W-1:0]  sum_shr;
`endif

    always_comb begin
        in_ready = !reset && (state_q == S_RUN) && (!out_valid_q || out_ready);
        ch_ok    = ({1'b0, in_channel} < CH_NUM);
        ch_idx   = ch_ok ? in_channel : '0;
        accept   = in_valid && in_ready;
        hit      = accept && ch_ok;
        // Channel-major history layout: address = channel*N + pointer.
        rd_addr  = {ch_idx, ptr_q[ch_idx]};
        x_old    = hist_q[rd_addr];
        sum_new  = sum_q[ch_idx]
                 + {{LOG2_TAPS{in_data[DATA_W-1]}}, in_data}
                 - {{LOG2_TAPS{x_old[DATA_W-1]}}, x_old};
`ifdef MOVE_AVG_ROUND_EN
        sum_rnd  = {sum_new[SUM_W-1], sum_new} + (SUM_W + 1)'(TAPS / 2);
        sum_shr  = sum_rnd >>> LOG2_TAPS;
`else
        sum_shr  = sum_new >>> LOG2_TAPS;
`endif
        avg      = sum_shr[DATA_W-1:0];
        result_d = switch ? avg : x_old;
    end

    // History RAM has no reset; the CLEAR walk zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                hist_q[clr_addr_q] <= '0;
            end else if (hit) begin
                hist_q[rd_addr] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_CLEAR;
            clr_addr_q    <= '0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                ptr_q[i] <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= S_RUN;
                    end
                end
                default: ;
            endcase

            if (hit) begin
                ptr_q[ch_idx] <= ptr_q[ch_idx] + 1'b1;
                sum_q[ch_idx] <= sum_new;
                out_valid_q   <= 1'b1;
                out_data_q    <= result_d;
                out_channel_q <= in_channel;
            end else if (out_ready) begin
                // Drained (or out-of-range sample consumed): idle output reads zero.
                out_valid_q   <= 1'b0;
                out_data_q    <= '0;
                out_channel_q <= '0;
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule
